// File: rtl/counter_ctrl.sv
// Four-digit BCD up/down counter with run/pause/clear control.
// A prescaler divides clk_core so the count advances once every TICK_DIV cycles while running.
module counter_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        clk_core,
  input  logic        rst_n,
  input  logic        btn_run,
  input  logic        btn_clr,
  input  logic        btn_dir,
  output logic [15:0] count_bcd,
  output logic        running,
  output logic        dir_up,
  output logic        wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   count_q, count_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          running_q, running_d;
  logic          step;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (btn_clr) begin
      state_d = IDLE;
    end else if (btn_run) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Step uses the current direction; a coinciding btn_dir only affects later steps.
  always_comb begin
    step      = (state_q == RUN) && (pre_q == PRE_MAX);
    pre_d     = pre_q;
    count_d   = count_q;
    wrap_d    = 1'b0;
    dir_d     = dir_q ^ btn_dir;
    running_d = (state_d == RUN);
    if (btn_clr || state_q == IDLE) begin
      pre_d   = '0;
      count_d = '0;
    end else if (step) begin
      pre_d   = '0;
      count_d = dir_q ? bcd_inc(count_q) : bcd_dec(count_q);
      wrap_d  = dir_q ? (count_q == 16'h9999) : (count_q == 16'h0000);
    end else if (state_q == RUN) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      count_q   <= '0;
      dir_q     <= 1'b1;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign count_bcd = count_q;
  assign running   = running_q;
  assign dir_up    = dir_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed and random checks of counter_ctrl (TICK_DIV=4) against an integer-arithmetic model.
module tb_counter_ctrl;

  localparam int TD = 4;

  logic        clk_core = 1'b0;
  logic        rst_n    = 1'b0;
  logic        btn_run  = 1'b0;
  logic        btn_clr  = 1'b0;
  logic        btn_dir  = 1'b0;
  logic [15:0] count_bcd;
  logic        running;
  logic        dir_up;
  logic        wrap;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: mode 0=idle 1=run 2=pause, count as plain integer 0..9999
  int m_mode;
  int m_pre;
  int m_count;
  bit m_dir;
  bit m_wrap;

  counter_ctrl #(.TICK_DIV(TD)) dut (
    .clk_core (clk_core),
    .rst_n    (rst_n),
    .btn_run  (btn_run),
    .btn_clr  (btn_clr),
    .btn_dir  (btn_dir),
    .count_bcd(count_bcd),
    .running  (running),
    .dir_up   (dir_up),
    .wrap     (wrap)
  );

  always #5 clk_core = ~clk_core;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " count"},   count_bcd,         to_bcd(m_count));
    check({tag, " running"}, {15'd0, running},  {15'd0, m_mode == 1});
    check({tag, " dir_up"},  {15'd0, dir_up},   {15'd0, m_dir});
    check({tag, " wrap"},    {15'd0, wrap},     {15'd0, m_wrap});
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pre   = 0;
    m_count = 0;
    m_dir   = 1'b1;
    m_wrap  = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit c, input bit d);
    bit step;
    step   = (m_mode == 1) && (m_pre == TD - 1);
    m_wrap = 1'b0;
    if (c || m_mode == 0) begin
      m_pre   = 0;
      m_count = 0;
    end else if (step) begin
      m_pre = 0;
      if (m_dir) begin
        m_wrap  = (m_count == 9999);
        m_count = (m_count + 1) % 10000;
      end else begin
        m_wrap  = (m_count == 0);
        m_count = (m_count + 9999) % 10000;
      end
    end else if (m_mode == 1) begin
      m_pre++;
    end
    if (c)      m_mode = 0;
    else if (r) m_mode = (m_mode == 1) ? 2 : 1;
    if (d) m_dir = !m_dir;
  endtask

  task automatic cycle(input bit r, input bit c, input bit d, input string tag);
    btn_run = r;
    btn_clr = c;
    btn_dir = d;
    @(posedge clk_core);
    model_edge(r, c, d);
    #1;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    btn_dir = 1'b0;
    check_model(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset count",   count_bcd,        16'h0000);
    check("reset running", {15'd0, running}, 16'd0);
    check("reset dir_up",  {15'd0, dir_up},  16'd1);
    check("reset wrap",    {15'd0, wrap},    16'd0);
    @(negedge clk_core);
    rst_n = 1'b1;

    // Start and first two steps
    cycle(1'b1, 1'b0, 1'b0, "start");
    check("start running", {15'd0, running}, 16'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "up1");
    check("first step", count_bcd, 16'h0001);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "up2");
    check("second step", count_bcd, 16'h0002);

    // Down from zero wraps to 9999, then 9998; turn around and wrap upward
    cycle(1'b0, 1'b1, 1'b0, "clear");
    cycle(1'b0, 1'b0, 1'b1, "dir down");
    check("dir down", {15'd0, dir_up}, 16'd0);
    cycle(1'b1, 1'b0, 1'b0, "start down");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "down1");
    check("down wrap count", count_bcd, 16'h9999);
    check("down wrap pulse", {15'd0, wrap}, 16'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "down2");
    check("9998", count_bcd, 16'h9998);
    check("wrap low", {15'd0, wrap}, 16'd0);
    cycle(1'b0, 1'b0, 1'b1, "dir up");
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, "up3");
    check("up 9999", count_bcd, 16'h9999);
    check("no wrap at 9999", {15'd0, wrap}, 16'd0);
    cycle(1'b0, 1'b0, 1'b0, "up wrap");
    check("up wrap count", count_bcd, 16'h0000);
    check("up wrap pulse", {15'd0, wrap}, 16'd1);
    cycle(1'b0, 1'b0, 1'b0, "after wrap");
    check("wrap one cycle", {15'd0, wrap}, 16'd0);

    // Pause at prescaler phase 2 (one edge already spent above), resume keeps phase
    cycle(1'b0, 1'b0, 1'b0, "pre2");
    cycle(1'b1, 1'b0, 1'b0, "pause");
    check("paused", {15'd0, running}, 16'd0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, "frozen");
    check("frozen count", count_bcd, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, "resume");
    check("resume no step", count_bcd, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, "resume step");
    check("resume step", count_bcd, 16'h0001);

    // Clear and run together on a step edge
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "to step");
    cycle(1'b1, 1'b1, 1'b0, "clr+run");
    check("clr count",   count_bcd,        16'h0000);
    check("clr running", {15'd0, running}, 16'd0);
    check("clr wrap",    {15'd0, wrap},    16'd0);
    cycle(1'b1, 1'b0, 1'b0, "run after clr");

    // Async reset mid-run while counting down
    cycle(1'b0, 1'b0, 1'b1, "dir down2");
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, "run down");
    #2;
    rst_n = 1'b0;
    #1;
    check("async count",   count_bcd,        16'h0000);
    check("async running", {15'd0, running}, 16'd0);
    check("async dir_up",  {15'd0, dir_up},  16'd1);
    check("async wrap",    {15'd0, wrap},    16'd0);
    model_reset();
    @(negedge clk_core);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, "post reset");

    // Random button traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 15) == 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk_core cycles per count step (legal range 2..2^26).
REQ-002 SHALL have port clk_core  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port btn_run  input  1  single-cycle debounced press pulse; toggles run/pause.
REQ-005 SHALL have port btn_clr  input  1  single-cycle debounced press pulse; clears count and stops.
REQ-006 SHALL have port btn_dir  input  1  single-cycle debounced press pulse; toggles count direction.
REQ-007 SHALL have port count_bcd  output  16  four BCD digits, [15:12] most significant, registered.
REQ-008 SHALL have port running  output  1  high while state is RUN, registered.
REQ-009 SHALL have port dir_up  output  1  1 = counting up, 0 = counting down, registered.
REQ-010 SHALL have port wrap  output  1  single-cycle pulse on 9999->0000 or 0000->9999 transition, registered.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, PAUSE.
REQ-012 SHALL transition IDLE->RUN, RUN->PAUSE, PAUSE->RUN on btn_run high at a clock edge.
REQ-013 SHALL transition any state->IDLE on btn_clr high, with btn_clr taking priority over a simultaneous btn_run.
REQ-014 SHALL in IDLE hold count_bcd at 0x0000 and prescaler at 0.
REQ-015 SHALL maintain a prescaler counting 0..TICK_DIV-1 only in RUN; hold its value in PAUSE; clear it in IDLE.
REQ-016 SHALL generate an internal step when state is RUN and prescaler equals TICK_DIV-1; on that edge prescaler returns to 0 and count_bcd updates.
REQ-017 SHALL therefore make the first step occur on the TICK_DIV-th edge after the edge entering RUN from IDLE; resuming from PAUSE continues the saved prescaler phase.
REQ-018 SHALL increment in BCD when dir_up=1: each digit 0..9, carry to next digit on 9->0; 9999 steps to 0000.
REQ-019 SHALL decrement in BCD when dir_up=0: each digit 9..0, borrow on 0->9; 0000 steps to 9999.
REQ-020 SHALL assert wrap for exactly the one cycle following a 9999->0000 (up) or 0000->9999 (down) step; never otherwise.
REQ-021 SHALL toggle dir_up on btn_dir in any state, including simultaneously with btn_clr or btn_run.
REQ-022 SHALL use the pre-toggle direction for a step coinciding with btn_dir; new direction applies from the next step.
REQ-023 SHALL on btn_clr coinciding with a step discard the step: count_bcd becomes 0x0000, wrap stays low.
REQ-024 SHALL ignore btn_run while btn_clr is high; btn_run in the cycle after clear starts from IDLE normally.
REQ-025 SHALL keep every digit of count_bcd within 0..9 at all times.
REQ-026 SHALL treat btn_run/btn_clr/btn_dir as already synchronous to clk_core; no internal debouncing or edge detection.

Reset
REQ-027 SHALL on rst_n low, immediately and independent of clk_core, force: state IDLE, prescaler 0, count_bcd 0x0000, running 0, dir_up 1, wrap 0.
REQ-028 SHALL resume normal operation on the first clk_core edge after rst_n deasserts; reset mid-RUN loses count and phase.

Verification (TICK_DIV=4)
REQ-029 SHALL verify: reset, btn_run pulse -> running=1 next cycle; count_bcd 0001 after 4 edges, 0002 after 8.
REQ-030 SHALL verify: preload to 9998 up, run 8 edges -> 9999 then 0000 with wrap high exactly one cycle.
REQ-031 SHALL verify: from IDLE, btn_dir then btn_run -> dir_up=0; after 4 edges count 9999, wrap pulse once.
REQ-032 SHALL verify: RUN at prescaler=2, btn_run -> PAUSE, count frozen 20 cycles; btn_run -> next step after 2 edges.
REQ-033 SHALL verify: btn_clr and btn_run same cycle while RUN at step edge -> IDLE, count 0000, running 0, wrap 0.
REQ-034 SHALL verify: rst_n low asynchronously mid-RUN with dir_up=0 -> all outputs at reset values before next clk_core edge.
